// File: rtl/demux1to2_stream.sv
// Stream demultiplexer: routes each accepted word to one of two independent
// 2-entry FIFOs chosen by sel; each FIFO drives its own valid/ready output.
module demux1to2_stream #(
    parameter int num_bits = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [num_bits-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sel,
    output logic [num_bits-1:0] out0_data,
    output logic                out0_valid,
    input  logic                out0_ready,
    output logic [1:0]          out0_count,
    output logic [num_bits-1:0] out1_data,
    output logic                out1_valid,
    input  logic                out1_ready,
    output logic [1:0]          out1_count
);

    // Storage is indexed [fifo][entry]; pointer and handshake vectors by fifo.
    logic [num_bits-1:0] mem_r [2][2];
    logic [1:0]          cnt_r [2];
    logic [1:0]          wptr_r;
    logic [1:0]          rptr_r;
    logic [1:0]          push_s;
    logic [1:0]          pop_s;
    logic [1:0]          full_s;
    logic [1:0]          nempty_s;
    logic [1:0]          out_ready_s;
    logic                in_ready_s;

    assign out_ready_s = {out1_ready, out0_ready};

    // Handshake decode: in_ready follows only the presented sel and occupancy.
    always_comb begin
        full_s   = 2'b00;
        nempty_s = 2'b00;
        push_s   = 2'b00;
        pop_s    = 2'b00;
        for (int k = 0; k < 2; k++) begin
            full_s[k]   = (cnt_r[k] == 2'd2);
            nempty_s[k] = (cnt_r[k] != 2'd0);
            pop_s[k]    = nempty_s[k] && out_ready_s[k];
        end
        in_ready_s = sel ? !full_s[1] : !full_s[0];
        push_s[0]  = in_valid && in_ready_s && !sel;
        push_s[1]  = in_valid && in_ready_s && sel;
    end

    // FIFO state: storage, wrapping 1-bit pointers and occupancy counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int e = 0; e < 2; e++) begin
                    mem_r[k][e] <= '0;
                end
                cnt_r[k] <= 2'd0;
            end
            wptr_r <= 2'b00;
            rptr_r <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push_s[k]) begin
                    mem_r[k][wptr_r[k]] <= in_data;
                    wptr_r[k]           <= ~wptr_r[k];
                end
                if (pop_s[k]) begin
                    rptr_r[k] <= ~rptr_r[k];
                end
                case ({push_s[k], pop_s[k]})
                    2'b10:   cnt_r[k] <= cnt_r[k] + 2'd1;
                    2'b01:   cnt_r[k] <= cnt_r[k] - 2'd1;
                    default: cnt_r[k] <= cnt_r[k];
                endcase
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out0_data  = mem_r[0][rptr_r[0]];
    assign out1_data  = mem_r[1][rptr_r[1]];
    assign out0_valid = nempty_s[0];
    assign out1_valid = nempty_s[1];
    assign out0_count = cnt_r[0];
    assign out1_count = cnt_r[1];

endmodule

// File: tb/tb_demux1to2_stream.sv
// Self-checking bench for demux1to2_stream: directed vector table, async
// reset sequence and a randomized stall run checked by per-output queues.
module tb_demux1to2_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sel;
    logic [7:0] out0_data, out1_data;
    logic       out0_valid, out1_valid;
    logic       out0_ready, out1_ready;
    logic [1:0] out0_count, out1_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int pushed = 0;
    int popped = 0;
    logic acc = 1'b0;

    demux1to2_stream #(.num_bits(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_count(out0_count),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_count(out1_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queues mirror FIFO contents; checks every edge.
    always @(posedge clk) begin
        logic       mrdy;
        logic [7:0] exp;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            mrdy = sel ? (q1.size() != 2) : (q0.size() != 2);
            chk("in_ready", in_ready, mrdy);
            chk("out0_valid", out0_valid, q0.size() != 0);
            chk("out1_valid", out1_valid, q1.size() != 0);
            chk("out0_count", out0_count, q0.size());
            chk("out1_count", out1_count, q1.size());
            if (q0.size() != 0 && out0_ready) begin
                exp = q0.pop_front();
                chk("out0_data", out0_data, exp);
                popped++;
            end
            if (q1.size() != 0 && out1_ready) begin
                exp = q1.pop_front();
                chk("out1_data", out1_data, exp);
                popped++;
            end
            if (in_valid && mrdy) begin
                if (sel) q1.push_back(in_data);
                else     q0.push_back(in_data);
                pushed++;
                acc = 1'b1;
            end
        end
    end

    typedef struct {
        logic       sel, vld;
        logic [7:0] d;
        logic       r0, r1, rdy;
        logic [1:0] c0, c1;
        logic [7:0] h0, h1;
    } vec_t;

    vec_t tbl[12];

    task automatic drive(input logic s, input logic v, input logic [7:0] d,
                         input logic r0, input logic r1);
        sel = s; in_valid = v; in_data = d; out0_ready = r0; out1_ready = r1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, cyc, pop_base;
        // sel, vld, data, r0, r1 | pre-edge in_ready | post-edge counts, heads
        tbl[0]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 8'h00, 8'hFF};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 8'h11, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 8'h11, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 8'h11, 8'h00};
        tbl[6]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 8'h11, 8'h33};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 8'h22, 8'h33};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 8'h00, 8'h00};
        tbl[9]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 8'hA5, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 8'h5A, 8'h00};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 8'h00, 8'h00};

        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #2;
        chk("rst_out0_valid", out0_valid, 1'b0);
        chk("rst_out1_valid", out1_valid, 1'b0);
        chk("rst_out0_data", out0_data, 8'h00);
        chk("rst_out1_data", out1_data, 8'h00);
        chk("rst_counts", {out0_count, out1_count}, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            sel = tbl[i].sel; in_valid = tbl[i].vld; in_data = tbl[i].d;
            out0_ready = tbl[i].r0; out1_ready = tbl[i].r1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].rdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out0_count", i), out0_count, tbl[i].c0);
            chk($sformatf("vec%0d_out1_count", i), out1_count, tbl[i].c1);
            chk($sformatf("vec%0d_out0_valid", i), out0_valid, tbl[i].c0 != 2'd0);
            chk($sformatf("vec%0d_out1_valid", i), out1_valid, tbl[i].c1 != 2'd0);
            if (tbl[i].c0 != 2'd0) chk($sformatf("vec%0d_out0_data", i), out0_data, tbl[i].h0);
            if (tbl[i].c1 != 2'd0) chk($sformatf("vec%0d_out1_data", i), out1_data, tbl[i].h1);
        end

        // Fill both FIFOs, then pulse reset between edges.
        drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
        chk("full_counts", {out0_count, out1_count}, 4'hA);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valids", {out0_valid, out1_valid}, 2'b00);
        chk("arst_counts", {out0_count, out1_count}, 4'h0);
        chk("arst_data", {out0_data, out1_data}, 16'h0000);
        chk("arst_in_ready", in_ready, 1'b1);
        q0.delete(); q1.delete();
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'h7E, 1'b1, 1'b1);
        chk("post_rst_valid", out0_valid, 1'b1);
        chk("post_rst_data", out0_data, 8'h7E);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("post_rst_empty", out0_valid, 1'b0);

        // Randomized traffic with stalls on both outputs.
        sent = 0; cyc = 0; pop_base = popped; in_valid = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom_range(0, 255));
                sel      = 1'($urandom_range(0, 1));
            end
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            acc = 1'b0;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        chk("random_sent", sent, 1000);
        in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("drain_q0_empty", q0.size(), 0);
        chk("drain_q1_empty", q1.size(), 0);
        chk("drain_valids", {out0_valid, out1_valid}, 2'b00);
        chk("random_popped", popped - pop_base, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
